// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Holds the state codes, the loss counter width and the counter sizing function.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    localparam int LOSS_W = 8;

    // Width that holds the largest of the three cycle counts without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// sync_2ff: single-bit two-flop synchronizer, async active-high reset to 0.
// Ports: clk, rst, d (async input), q (synchronized output).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on refclk: holds PLL in reset, waits for a stable
// lock, releases core reset, retries on timeout and reports failure.
// Ports: refclk, rst (async, high), pll_locked (async), restart (1-cycle pulse)
//        -> pll_rst, core_reset, ready, fail, state[2:0], retry_cnt, loss_cnt[7:0].
// Optional macro PLL_SEQ_LOSS_CNT_EN: when defined, loss_cnt counts lock losses
// in RUN (saturating); otherwise loss_cnt is tied to 0.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic                           refclk,
    input  logic                           rst,
    input  logic                           pll_locked,
    input  logic                           restart,
    output logic                           pll_rst,
    output logic                           core_reset,
    output logic                           ready,
    output logic                           fail,
    output logic [2:0]                     state,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
    output logic [LOSS_W-1:0]              loss_cnt
);

    localparam int CW = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic          locked_s;
    state_t        state_q;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] tcnt;
    logic          timeout;
    logic          pll_rst_nx;
    logic          core_reset_nx;
    logic          ready_nx;
    logic          fail_nx;

    sync_2ff u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        timeout  = 1'b0;
        if (restart) begin
            state_nx = S_RESET;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (cnt == RST_LAST) state_nx = S_WAIT;
                end
                S_WAIT: begin
                    if (locked_s) begin
                        state_nx = S_STABLE;
                    end else if (tcnt == TO_LAST) begin
                        timeout  = 1'b1;
                        state_nx = (retry_cnt < RETRY_MAX) ? S_RESET : S_FAIL;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_nx = S_WAIT;
                    end else if (cnt == STB_LAST) begin
                        state_nx = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!locked_s) state_nx = S_RESET;
                end
                S_FAIL: begin
                    state_nx = S_FAIL;
                end
                default: begin
                    state_nx = S_RESET;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so the registered copies line up
    // with the state register.
    always_comb begin
        pll_rst_nx    = 1'b1;
        core_reset_nx = 1'b1;
        ready_nx      = 1'b0;
        fail_nx       = 1'b0;
        case (state_nx)
            S_WAIT, S_STABLE: begin
                pll_rst_nx = 1'b0;
            end
            S_RUN: begin
                pll_rst_nx    = 1'b0;
                core_reset_nx = 1'b0;
                ready_nx      = 1'b1;
            end
            S_FAIL: begin
                fail_nx = 1'b1;
            end
            default: begin
                pll_rst_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst    <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            pll_rst    <= pll_rst_nx;
            core_reset <= core_reset_nx;
            ready      <= ready_nx;
            fail       <= fail_nx;
        end
    end

    // Shared counter for the reset hold and the stable-lock run; cleared on
    // every state change so each phase starts from zero.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || (state_nx != state_q)) begin
            cnt <= '0;
        end else if ((state_q == S_RESET) || (state_q == S_STABLE)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Lock timeout spans WAIT and STABLE: it holds while STABLE and resumes
    // on a fallback to WAIT, so lock glitches cannot extend the deadline.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (restart || ((state_q != S_WAIT) && (state_q != S_STABLE))) begin
            tcnt <= '0;
        end else if ((state_q == S_WAIT) && (state_nx == S_WAIT)) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (restart) begin
            retry_cnt <= '0;
        end else if ((state_nx == S_RUN) && (state_q != S_RUN)) begin
            retry_cnt <= '0;
        end else if (timeout && (retry_cnt < RETRY_MAX)) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic              loss_evt;
    logic [LOSS_W-1:0] loss_q;

    // A loss in RUN is counted even when a restart wins the transition.
    assign loss_evt = (state_q == S_RUN) && !locked_s;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != {LOSS_W{1'b1}})) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif

    assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard testbench for pll_reset_sequencer with a cycle-level reference
// model; directed scenarios plus randomized lock/restart stimulus.
module tb_pll_reset_sequencer;

    localparam int RC = 4;
    localparam int TO = 20;
    localparam int SC = 8;
    localparam int MR = 2;
`ifdef PLL_SEQ_LOSS_CNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    typedef logic [16:0] obs_t;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart    = 1'b0;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    pll_reset_sequencer #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (SC),
        .MAX_RETRY     (MR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .core_reset (core_reset),
        .ready      (ready),
        .fail       (fail),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 refclk = ~refclk;

    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    obs_t sbq[$];
    obs_t exp_o;
    obs_t act_o;

    // Reference model: phase 0..4 with remaining-reset, waited, stable-run counts.
    int m_ph, m_rl, m_wu, m_sr, m_rt, m_ls;
    bit m_lk;
    bit hist[$];

    always @(posedge refclk) cyc++;

    function automatic obs_t expect_now();
        return {3'(m_ph), (m_ph == 0 || m_ph == 4), (m_ph != 3), (m_ph == 3),
                (m_ph == 4), 2'(m_rt), 8'(m_ls)};
    endfunction

    task automatic step();
        bit loss;
        loss = (m_ph == 3) && !m_lk;
        if (loss && EN && m_ls < 255) m_ls++;
        if (restart) begin
            m_ph = 0; m_rl = RC; m_rt = 0;
        end else begin
            case (m_ph)
                0: begin
                    m_rl--;
                    if (m_rl == 0) begin m_ph = 1; m_wu = 0; end
                end
                1: begin
                    if (m_lk) begin
                        m_ph = 2; m_sr = 0;
                    end else begin
                        m_wu++;
                        if (m_wu == TO) begin
                            if (m_rt < MR) begin m_rt++; m_ph = 0; m_rl = RC; end
                            else m_ph = 4;
                        end
                    end
                end
                2: begin
                    if (!m_lk) m_ph = 1;
                    else begin
                        m_sr++;
                        if (m_sr == SC) begin m_ph = 3; m_rt = 0; end
                    end
                end
                3: if (!m_lk) begin m_ph = 0; m_rl = RC; end
                default: ;
            endcase
        end
    endtask

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_rl = RC; m_wu = 0; m_sr = 0; m_rt = 0; m_ls = 0;
            hist.delete();
            sbq.delete();
            sbq.push_back(expect_now());
        end else begin
            hist.push_front(pll_locked);
            if (hist.size() > 3) void'(hist.pop_back());
            m_lk = (hist.size() == 3) ? hist[2] : 1'b0;
            step();
            sbq.push_back(expect_now());
        end
    end

    always @(negedge refclk) begin
        if (mon_en) begin
            n_chk++;
            if (sbq.size() == 0) begin
                $display("FAIL sb_underflow at cyc %0d: got empty queue, required one entry", cyc);
            end else begin
                exp_o = sbq.pop_front();
                act_o = {state, pll_rst, core_reset, ready, fail, retry_cnt, loss_cnt};
                if (act_o === exp_o) n_pass++;
                else $display("FAIL cycle_obs at cyc %0d: got %h, required %h", cyc, act_o, exp_o);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, want);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    function automatic int sig_val(input int which);
        case (which)
            0: return int'(ready);
            1: return int'(state);
            2: return int'(fail);
            default: return int'(core_reset);
        endcase
    endfunction

    task automatic wait_sig(input int which, input int val, input int lim, input string name);
        int n;
        n = 0;
        while (sig_val(which) != val && n < lim) begin
            @(negedge refclk);
            n++;
        end
        if (sig_val(which) != val) chk(name, sig_val(which), val);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask

    int t0;

    initial begin
        @(posedge refclk);
        mon_en = 1'b1;
        tick(3);
        chk("reset_state", int'(state), 0);
        chk("reset_pll_rst", int'(pll_rst), 1);
        rst = 1'b0;

        // Nominal bring-up.
        tick(10);
        pll_locked = 1'b1;
        t0 = cyc;
        wait_sig(0, 1, 100, "bringup_timeout");
        chk("bringup_latency", cyc - t0, 11);
        chk("run_state", int'(state), 3);
        chk("run_core_reset", int'(core_reset), 0);

        // One-cycle lock glitch while stabilising.
        pulse_restart();
        wait_sig(1, 2, 50, "reach_stable");
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        t0 = cyc;
        wait_sig(0, 1, 100, "glitch_timeout");
        chk("glitch_latency", cyc - t0, 11);

        // Timeouts to failure, then restart.
        pll_locked = 1'b0;
        pulse_restart();
        wait_sig(2, 1, 400, "reach_fail");
        chk("fail_retry_cnt", int'(retry_cnt), MR);
        chk("fail_pll_rst", int'(pll_rst), 1);
        pulse_restart();
        chk("restart_state", int'(state), 0);
        chk("restart_fail", int'(fail), 0);
        chk("restart_retry", int'(retry_cnt), 0);

        // Lock loss in RUN.
        pll_locked = 1'b1;
        wait_sig(0, 1, 100, "run_timeout");
        pll_locked = 1'b0;
        t0 = cyc;
        wait_sig(3, 1, 20, "loss_detect");
        chk("loss_latency", cyc - t0, 3);
        chk("loss_cnt_1", int'(loss_cnt), EN ? 1 : 0);

        // Restart on the same cycle as a lock loss.
        pll_locked = 1'b1;
        wait_sig(0, 1, 100, "run2_timeout");
        pll_locked = 1'b0;
        tick(2);
        pulse_restart();
        chk("collide_state", int'(state), 0);
        chk("collide_loss", int'(loss_cnt), EN ? 2 : 0);

        // Many losses with random dwell times: saturation.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            wait_sig(0, 1, 100, "relock_run");
            tick($urandom_range(0, 4));
            pll_locked = 1'b0;
            wait_sig(3, 1, 20, "loss_loop");
        end
        chk("loss_sat", int'(loss_cnt), EN ? 255 : 0);

        // Random lock noise and occasional restarts.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 7) pll_locked = ($urandom_range(0, 15) != 0);
            else pll_locked = ($urandom_range(0, 1) == 1);
            restart = ($urandom_range(0, 49) == 0);
            tick(1);
        end
        restart = 1'b0;

        // Async reset in the middle of STABLE.
        pll_locked = 1'b1;
        pulse_restart();
        wait_sig(1, 2, 50, "reach_stable2");
        tick(2);
        #2 rst = 1'b1;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_pll_rst", int'(pll_rst), 1);
        chk("async_core_reset", int'(core_reset), 1);
        chk("async_ready", int'(ready), 0);
        chk("async_fail", int'(fail), 0);
        chk("async_retry", int'(retry_cnt), 0);
        chk("async_loss", int'(loss_cnt), 0);
        tick(3);
        rst = 1'b0;
        tick(5);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
